// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command issuer: data width,
// opcodes, FSM state encoding and the captured-response record.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_SLT = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] f;
    logic              overflow;
    logic              zero;
    logic [OP_W-1:0]   op;
  } rsp_t;

  // Opcodes above SLT have no ALU meaning and are answered with a fixed result
  function automatic logic op_unused(input logic [OP_W-1:0] op);
    return (op > OP_SLT);
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Reference model of the external ALU, used to check captured results.
// Only instantiated when ALU_ISSUE_CHECK_EN is defined.
module alu_golden
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] exp_f,
  output logic              exp_zero,
  output logic              checkable
);

  logic [DATA_W-1:0] diff;

  always_comb begin
    diff      = x - y;
    exp_f     = '0;
    checkable = 1'b1;
    case (op)
      OP_ADD:  exp_f = x + y;
      OP_OR:   exp_f = x | y;
      OP_AND:  exp_f = x & y;
      OP_SUB:  exp_f = diff;
      OP_SLT:  exp_f = {{(DATA_W-1){1'b0}}, diff[DATA_W-1]};
      default: checkable = 1'b0;
    endcase
    exp_zero = (exp_f == '0);
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to an external combinational ALU, holds the
// operands for SETTLE_CYCLES, then presents the captured result as a response.
// Optional golden-model check enabled by defining ALU_ISSUE_CHECK_EN.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_x,
  input  logic [DATA_W-1:0] cmd_y,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_f,
  output logic              rsp_overflow,
  output logic              rsp_zero,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_mismatch,
  output logic              err_sticky,
  output logic              busy
);

  // A zero settle time still needs one cycle for the ALU to see its inputs
  localparam logic [7:0] SETTLE_EFF = (SETTLE_CYCLES == 0) ? 8'd1 : 8'(SETTLE_CYCLES);

  logic [1:0] state;
  logic [7:0] cnt;
  rsp_t       rsp_q;
  logic       capture;

  assign capture   = (state == ST_DRIVE) && (cnt <= 8'd1);
  assign cmd_ready = rst_n && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_opcode <= '0;
      rsp_q      <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_x      <= cmd_x;
            alu_y      <= cmd_y;
            alu_opcode <= cmd_op;
            cnt        <= op_unused(cmd_op) ? 8'd1 : SETTLE_EFF;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (capture) begin
            cnt       <= 8'd0;
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            if (op_unused(alu_opcode)) begin
              rsp_q <= '{f: '0, overflow: 1'b0, zero: 1'b1, op: alu_opcode};
            end else begin
              rsp_q <= '{f: alu_f, overflow: alu_overflow, zero: alu_zero, op: alu_opcode};
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_f        = rsp_q.f;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_op       = rsp_q.op;

`ifdef ALU_ISSUE_CHECK_EN
  logic [DATA_W-1:0] exp_f;
  logic              exp_zero;
  logic              checkable;
  logic              mismatch_now;
  logic              mismatch_q;
  logic              sticky_q;

  alu_golden u_golden (
    .x         (alu_x),
    .y         (alu_y),
    .op        (alu_opcode),
    .exp_f     (exp_f),
    .exp_zero  (exp_zero),
    .checkable (checkable)
  );

  assign mismatch_now = checkable && ((alu_f != exp_f) || (alu_zero != exp_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else if (capture) begin
      mismatch_q <= mismatch_now;
      sticky_q   <= sticky_q | mismatch_now;
    end
  end

  assign rsp_mismatch = mismatch_q;
  assign err_sticky   = sticky_q;
`else
  assign rsp_mismatch = 1'b0;
  assign err_sticky   = 1'b0;
`endif

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, number of cycles ALU inputs are held before the result is sampled (legal 1..255).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  issuer can accept a command
- cmd_x, cmd_y  in  32  operands
- cmd_op  in  3  opcode
- alu_x, alu_y  out  32  operands driven to the external ALU
- alu_opcode  out  3  opcode driven to the ALU
- alu_f  in  32  ALU result
- alu_overflow, alu_zero  in  1  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_f  out  32  captured result
- rsp_overflow, rsp_zero  out  1  captured flags
- rsp_op  out  3  opcode of the response
- rsp_mismatch  out  1  golden-check failure for this response
- err_sticky  out  1  any mismatch since reset
- busy  out  1  state is not IDLE

Function
REQ-003 SHALL implement FSM states IDLE, DRIVE, RESP.
REQ-004 SHALL drive cmd_ready=1 only in IDLE.
REQ-005 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1; at that edge it loads alu_x, alu_y, alu_opcode from cmd_* and enters DRIVE.
REQ-006 SHALL remain in DRIVE for exactly SETTLE_CYCLES cycles, using an 8-bit down-counter.
REQ-007 SHALL, on the edge ending the last DRIVE cycle, capture alu_f, alu_overflow, alu_zero and alu_opcode into rsp_* and raise rsp_valid; rsp_valid rises SETTLE_CYCLES edges after the accepting edge.
REQ-008 SHALL hold rsp_valid and all rsp_* stable in RESP until an edge with rsp_ready=1, then return to IDLE; minimum command period is SETTLE_CYCLES+2 cycles.
REQ-009 SHALL hold alu_x, alu_y, alu_opcode stable from acceptance until the next acceptance, including through RESP and IDLE.
REQ-010 SHALL handle opcodes 5..7 (unused): accepted, DRIVE skipped, RESP entered on the next edge with rsp_f=0, rsp_overflow=0, rsp_zero=1.
REQ-011 SHALL treat SETTLE_CYCLES=0 as 1.
REQ-012 SHALL ignore cmd_valid outside IDLE; a command held across RESP is accepted on the first IDLE cycle.
REQ-013 SHALL drive busy = (state != IDLE).

Reset
REQ-014 SHALL, while rst_n=0 (asynchronous, including mid-DRIVE or mid-RESP), set state=IDLE, counter=0, rsp_valid=0, all rsp_*=0, alu_*=0, rsp_mismatch=0, err_sticky=0, cmd_ready=1 once rst_n=1.

Configuration
REQ-015 SHALL, with macro ALU_ISSUE_CHECK_EN defined, compute the expected result at capture with a golden model:
- add: x+y
- or: x|y
- and: x&y
- sub: x-y
- slt: bit0=(x-y)[31], other bits 0
- expected zero: (f==0)
It sets rsp_mismatch if rsp_f or rsp_zero differ from expected, and sets err_sticky (cleared only by reset).
REQ-016 SHALL, without ALU_ISSUE_CHECK_EN, keep rsp_mismatch and err_sticky ports present but tied to 0, and instantiate no golden logic.

Structure
REQ-017 SHALL take opcode constants (OP_ADD=0, OP_OR=1, OP_AND=2, OP_SUB=3, OP_SLT=4), data width 32, and FSM state encoding from shared package alu_pkg.
REQ-018 SHALL place the golden model in sub-module alu_golden, instantiated only under ALU_ISSUE_CHECK_EN.

Verification
REQ-019 SHALL cover these directed scenarios:
- SETTLE_CYCLES=4; cmd x=1024, y=128, op=0, ALU model correct -> rsp_valid exactly 4 edges after acceptance, rsp_f=1152, rsp_zero=0.
- op=3, x=5, y=7 -> rsp_f=0xFFFFFFFE; op=4 same operands -> rsp_f=1.
- rsp_ready low 3 cycles in RESP -> rsp_* stable, cmd_ready=0, new cmd_valid not accepted until 1 cycle after the rsp_ready edge.
- op=6 -> rsp_valid 1 edge after acceptance, rsp_f=0, rsp_zero=1.
- rst_n pulsed low in the 2nd DRIVE cycle -> all outputs 0 immediately, cmd_ready=1 after release, no rsp_valid.
- ALU_ISSUE_CHECK_EN defined, ALU model forces alu_f=0 for x=3, y=4, op=0 -> rsp_mismatch=1, err_sticky=1 persisting over the next correct command.
